// File: rtl/cache_mem_arbiter.sv
// Round-robin arbiter sharing one main-memory port between the I-cache and D-cache
// refill/writeback engines; sequences a full block burst for the granted requester.
//
// state  | meaning
// -------+------------------------------------------------------------
// S_IDLE | no burst; arbitrate among pending requests
// S_BUSY | burst in progress, one word per mem_ack
// S_DONE | single-cycle end of burst: done pulse, grant released
module cache_mem_arbiter #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int BLOCK_WORDS = 4
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic [1:0]                     req,
    input  logic [1:0]                     we,
    input  logic [ADDR_WIDTH-1:0]          addr0,
    input  logic [ADDR_WIDTH-1:0]          addr1,
    input  logic [DATA_WIDTH-1:0]          wdata0,
    input  logic [DATA_WIDTH-1:0]          wdata1,
    output logic [1:0]                     gnt,
    output logic [$clog2(BLOCK_WORDS)-1:0] word_idx,
    output logic [1:0]                     rvalid,
    output logic [DATA_WIDTH-1:0]          rdata,
    output logic [1:0]                     done,
    output logic                           mem_req,
    output logic                           mem_we,
    output logic [ADDR_WIDTH-1:0]          mem_addr,
    output logic [DATA_WIDTH-1:0]          mem_wdata,
    input  logic [DATA_WIDTH-1:0]          mem_rdata,
    input  logic                           mem_ack
);

    localparam int IDX_W = $clog2(BLOCK_WORDS);
    localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'(BLOCK_WORDS * 4 - 1);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic                    cur;
    logic                    last_grant;
    logic                    we_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic                    win;
    logic                    last_word;

    assign last_word = (word_idx == IDX_W'(BLOCK_WORDS - 1));

    always_ff @(posedge clk) begin
        if (rstn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // On a tie the requester that did not own the previous burst wins.
    always_comb begin
        win = 1'b0;
        if (req == 2'b10) begin
            win = 1'b1;
        end else if (req == 2'b11) begin
            win = ~last_grant;
        end
        state_nxt = state;
        case (state)
            S_IDLE:  if (req != 2'b00) state_nxt = S_BUSY;
            S_BUSY:  if (mem_ack && last_word) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            gnt        <= '0;
            word_idx   <= '0;
            rvalid     <= '0;
            rdata      <= '0;
            done       <= '0;
            cur        <= 1'b0;
            last_grant <= 1'b1;
            we_q       <= 1'b0;
            addr_q     <= '0;
        end else begin
            rvalid <= '0;
            done   <= '0;
            case (state)
                S_IDLE: begin
                    if (req != 2'b00) begin
                        cur      <= win;
                        gnt      <= win ? 2'b10 : 2'b01;
                        we_q     <= win ? we[1] : we[0];
                        addr_q   <= win ? addr1 : addr0;
                        word_idx <= '0;
                    end
                end
                S_BUSY: begin
                    if (mem_ack) begin
                        word_idx <= word_idx + 1'b1;
                        if (!we_q) begin
                            rvalid <= gnt;
                            rdata  <= mem_rdata;
                        end
                        if (last_word) begin
                            gnt  <= '0;
                            done <= gnt;
                        end
                    end
                end
                S_DONE: last_grant <= cur;
                default: ;
            endcase
        end
    end

    // Memory side is combinational from registered state; address advances the cycle after ack.
    always_comb begin
        mem_req   = (state == S_BUSY);
        mem_we    = mem_req & we_q;
        mem_addr  = '0;
        mem_wdata = '0;
        if (mem_req) begin
            mem_addr = (addr_q & ~OFF_MASK) + ADDR_WIDTH'({word_idx, 2'b00});
        end
        if (mem_we) begin
            mem_wdata = cur ? wdata1 : wdata0;
        end
    end

endmodule

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
Shares one main-memory port between the instruction-cache and data-cache refill/writeback engines of the pipelined RISC-V core.
- Grants the port to one requester per transfer (round-robin) and sequences a whole cache-block burst of BLOCK_WORDS words.
- Generates per-word memory addresses and steers read data back to the granted cache.
- Sits between both set-associative caches and the main memory model.

Parameters:
ADDR_WIDTH, 32, byte-address width
DATA_WIDTH, 32, word width
BLOCK_WORDS, 4, words per cache block (power of 2, >=2)

Ports:
clk  in  1  clock, all logic on rising edge
rstn  in  1  synchronous reset, active-high (1 = reset)
req  in  2  per-requester transfer request; bit0 = I-cache, bit1 = D-cache
we  in  2  per-requester: 1 = write burst (writeback), 0 = read burst (refill)
addr0  in  ADDR_WIDTH  requester 0 block address
addr1  in  ADDR_WIDTH  requester 1 block address
wdata0  in  DATA_WIDTH  requester 0 write word for current word_idx
wdata1  in  DATA_WIDTH  requester 1 write word for current word_idx
gnt  out  2  one-hot grant, held for the whole burst
word_idx  out  $clog2(BLOCK_WORDS)  index of the word currently on the memory port
rvalid  out  2  one-cycle pulse per returned read word to the granted requester
rdata  out  DATA_WIDTH  read word, valid when rvalid != 0
done  out  2  one-cycle pulse to the granted requester at burst end
mem_req  out  1  memory access request
mem_we  out  1  memory write enable
mem_addr  out  ADDR_WIDTH  memory byte address
mem_wdata  out  DATA_WIDTH  memory write data
mem_rdata  in  DATA_WIDTH  memory read data, valid with mem_ack
mem_ack  in  1  memory completes current word this cycle

Behaviour:
- Reset values: gnt=0, word_idx=0, rvalid=0, rdata=0, done=0, mem_req=0, mem_we=0, mem_addr=0; state=IDLE; last_grant=1, so requester 0 wins the first tie.
- States:
  - IDLE: if req!=0, pick a winner and register gnt, captured block address, we and word_idx=0, then go to BUSY. Single request: that requester wins. Both requesting: the requester that is not last_grant wins.
  - BUSY: mem_req=1. On mem_ack, increment word_idx; after the last word (word_idx==BLOCK_WORDS-1 with mem_ack), go to DONE.
  - DONE: for one cycle, done[g]=1, gnt=0, mem_req=0, last_grant=g, then go to IDLE.
- Latency:
  - req sampled in IDLE at cycle t: gnt and mem_req are high from t+1.
  - Minimum burst with mem_ack always 1 is BLOCK_WORDS BUSY cycles plus 1 DONE cycle.
  - Requests seen during DONE are arbitrated only in the following IDLE cycle, so there is at least 1 idle cycle between bursts.
- Address:
  - Block base = captured address with the low $clog2(BLOCK_WORDS*4) bits forced to 0.
  - mem_addr = base + word_idx*4. Combinational from registered state; it changes the cycle after mem_ack.
  - Address inputs are ignored after capture.
- Write burst:
  - mem_we=1 and mem_wdata = wdata of the granted requester, combinational pass-through, so the requester supplies the word for word_idx.
  - rvalid stays 0.
- Read burst:
  - On mem_ack, rdata <= mem_rdata and rvalid[g] <= 1, registered one cycle after the ack.
  - The last word's rvalid coincides with the DONE cycle's done pulse.
- mem_ack with mem_req=0 is ignored.
- mem_ack held low stalls BUSY indefinitely; mem_addr and mem_wdata stay stable.
- A requester dropping req mid-burst does not abort: the burst completes and done still pulses.
- A requester must hold req until done. If req is still high in the IDLE after DONE, it is a new request.
- Reset asserted mid-burst: the next cycle is IDLE with all outputs at reset values, no done pulse, and last_grant=1.
- Invariants: gnt is never two-hot; rvalid and done only ever appear on the granted bit.

Test Plan:
1. Read from requester 0 only: addr0=0x104, we=0, mem_ack=1 every cycle, mem_rdata=A,B,C,D -> mem_addr 0x100,0x104,0x108,0x10C on consecutive cycles; rvalid[0] pulses with rdata A..D; done[0] pulses once with D.
2. Both requesters raise req in the same cycle after reset, both reads -> requester 0 burst first; requester 1 granted on the IDLE cycle after done[0]; then both re-request -> requester 0 again (strict alternation).
3. Write burst on requester 1: addr1=0x2C, we=1, bench drives wdata1=0x10+word_idx -> mem_we=1, mem_addr 0x20..0x2C, mem_wdata 0x10..0x13, rvalid stays 0, done[1] after 4 acks.
4. mem_ack stall: ack only every 3rd cycle -> mem_addr held across the stall cycles; word_idx advances only on ack; total BUSY = 12 cycles.
5. Reset mid-burst: assert rstn after the 2nd ack of a read -> next cycle gnt=0, mem_req=0, no done; a new requester-1-only request is then granted normally starting at word 0.
6. Requester 0 drops req after the first ack -> burst still completes 4 words and done[0] pulses.
